// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, mode-register fields and
// burst/CAS decode helpers used by both the controller and the device emulator.
package sdram_pkg;

  // {csn, rasn, casn, wen}
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_BST   = 4'b0110;
  localparam logic [3:0] CMD_NOP   = 4'b0111;

  localparam int MR_BL_LSB = 0;
  localparam int MR_BT_BIT = 3;
  localparam int MR_CL_LSB = 4;
  localparam int MR_WB_BIT = 9;

  localparam logic [9:0] MODE_RESET = 10'h020;
  localparam logic [2:0] CL_2 = 3'd2;
  localparam logic [2:0] CL_3 = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RBURST = 2'd1,
    ST_WBURST = 2'd2
  } burst_state_t;

  // Supported: CL 2/3, sequential, BL 1/2/4/8.
  function automatic logic mode_ok(input logic [9:0] m);
    return ((m[MR_CL_LSB +: 3] == CL_2) || (m[MR_CL_LSB +: 3] == CL_3)) &&
           !m[MR_BT_BIT] && !m[MR_BL_LSB + 2];
  endfunction

  // Burst length minus one, doubling as the column wrap mask.
  function automatic logic [2:0] bl_mask(input logic [1:0] bl);
    case (bl)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] wrap_inc(input logic [2:0] c, input logic [2:0] mask);
    return (c & ~mask) | ((c + 3'd1) & mask);
  endfunction

endpackage

// File: rtl/sdram_emu_ram.sv
// Single-port synchronous RAM, 16-bit words with per-byte write enables.
// Write-first: a written byte appears on rdata at the same edge.
module sdram_emu_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    be,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);
  localparam int DEPTH = 1 << AW;

  logic [15:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int j = 0; j < 2; j++) begin
        if (be[j]) mem[addr][8*j +: 8] <= wdata[8*j +: 8];
      end
      rdata <= {be[1] ? wdata[15:8] : mem[addr][15:8],
                be[0] ? wdata[7:0]  : mem[addr][7:0]};
    end
  end

endmodule

// File: rtl/sdram_device_emu.sv
// SDR SDRAM device-side responder: command decode, bank table, burst FSM and
// CAS-latency output pipeline in front of an on-chip RAM.
module sdram_device_emu
  import sdram_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int COL_W  = 9,
  parameter int ROW_W  = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sdram_cke,
  input  logic        sdram_csn,
  input  logic        sdram_rasn,
  input  logic        sdram_casn,
  input  logic        sdram_wen,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_addr,
  input  logic [1:0]  sdram_dqm,
  input  logic [15:0] sdram_dq_i,
  output logic [15:0] sdram_dq_o,
  output logic        sdram_dq_oe,
  output logic [9:0]  mode_reg,
  output logic [3:0]  err
);

  logic [3:0] cmd;
  logic is_rd, is_wr, is_rw, is_bst, burst_go, last_beat, wr_beat, rd_beat, cl3;
  logic [2:0] rd_last, wr_last, cmd_last;
  burst_state_t state, state_next;

  logic [ROW_W-1:0] open_row [4];
  logic [3:0]       active;

  logic [1:0]       b_ba;
  logic [ROW_W-1:0] b_row;
  logic [COL_W-1:0] b_col;
  logic [2:0]       b_cnt, b_last;
  logic             b_ap;

  logic [1:0]        ram_ba, ram_be;
  logic [ROW_W-1:0]  ram_row;
  logic [COL_W-1:0]  ram_col;
  logic [MEM_AW-1:0] ram_addr;
  logic [15:0]       ram_rdata, d_b;
  logic              v_a, v_b, dqm_d;

  assign cmd       = {sdram_csn, sdram_rasn, sdram_casn, sdram_wen};
  assign is_rd     = sdram_cke && (cmd == CMD_READ);
  assign is_wr     = sdram_cke && (cmd == CMD_WRITE);
  assign is_rw     = is_rd || is_wr;
  assign is_bst    = sdram_cke && (cmd == CMD_BST);
  // Unsupported mode settings fall back to CL2/BL1.
  assign cl3       = mode_ok(mode_reg) && (mode_reg[MR_CL_LSB +: 3] == CL_3);
  assign rd_last   = mode_ok(mode_reg) ? bl_mask(mode_reg[1:0]) : 3'd0;
  assign wr_last   = mode_reg[MR_WB_BIT] ? 3'd0 : rd_last;
  assign cmd_last  = is_rd ? rd_last : wr_last;
  assign burst_go  = sdram_cke && !is_rw && !is_bst && (state != ST_IDLE);
  assign last_beat = (b_cnt == b_last);
  assign wr_beat   = is_wr || (burst_go && (state == ST_WBURST));
  assign rd_beat   = is_rd || (burst_go && (state == ST_RBURST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (is_rw) begin
      if (cmd_last == 3'd0) state_next = ST_IDLE;
      else                  state_next = is_rd ? ST_RBURST : ST_WBURST;
    end else if (is_bst) begin
      state_next = ST_IDLE;
    end else if (burst_go && last_beat) begin
      state_next = ST_IDLE;
    end
  end

  // A new command addresses the RAM directly so beat 0 lands on its own edge.
  always_comb begin
    ram_ba  = b_ba;
    ram_row = b_row;
    ram_col = b_col;
    if (is_rw) begin
      ram_ba  = sdram_ba;
      ram_row = open_row[sdram_ba];
      ram_col = sdram_addr[COL_W-1:0];
    end
    ram_be   = wr_beat ? ~sdram_dqm : 2'b00;
    ram_addr = MEM_AW'({ram_ba, ram_row, ram_col});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_ba   <= '0;
      b_row  <= '0;
      b_col  <= '0;
      b_cnt  <= '0;
      b_last <= '0;
      b_ap   <= 1'b0;
    end else if (is_rw) begin
      b_ba   <= sdram_ba;
      b_row  <= open_row[sdram_ba];
      b_col  <= {sdram_addr[COL_W-1:3], wrap_inc(sdram_addr[2:0], cmd_last)};
      b_cnt  <= 3'd1;
      b_last <= cmd_last;
      b_ap   <= sdram_addr[10];
    end else if (burst_go) begin
      b_col  <= {b_col[COL_W-1:3], wrap_inc(b_col[2:0], b_last)};
      b_cnt  <= b_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= '0;
      mode_reg <= MODE_RESET;
      err      <= '0;
      for (int i = 0; i < 4; i++) open_row[i] <= '0;
    end else if (sdram_cke) begin
      if (is_rw && sdram_addr[10] && (cmd_last == 3'd0)) active[sdram_ba] <= 1'b0;
      if (burst_go && last_beat && b_ap) active[b_ba] <= 1'b0;
      if (is_rw && !active[sdram_ba]) err[0] <= 1'b1;
      case (cmd)
        CMD_ACT: begin
          open_row[sdram_ba] <= sdram_addr[ROW_W-1:0];
          active[sdram_ba]   <= 1'b1;
          if (active[sdram_ba]) err[1] <= 1'b1;
        end
        CMD_PRE: begin
          if (sdram_addr[10]) active <= '0;
          else                active[sdram_ba] <= 1'b0;
        end
        CMD_REF: if (|active) err[2] <= 1'b1;
        CMD_MRS: begin
          mode_reg <= sdram_addr[9:0];
          if (!mode_ok(sdram_addr[9:0])) err[3] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // CAS pipeline: RAM output (v_a), optional extra stage for CL3 (v_b), then dq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_a         <= 1'b0;
      v_b         <= 1'b0;
      d_b         <= '0;
      dqm_d       <= 1'b0;
      sdram_dq_o  <= '0;
      sdram_dq_oe <= 1'b0;
    end else if (sdram_cke) begin
      dqm_d <= &sdram_dqm;
      d_b   <= ram_rdata;
      if (is_wr) begin
        v_a         <= 1'b0;
        v_b         <= 1'b0;
        sdram_dq_oe <= 1'b0;
        sdram_dq_o  <= '0;
      end else begin
        v_a <= rd_beat;
        v_b <= v_a;
        if ((cl3 ? v_b : v_a) && !dqm_d) begin
          sdram_dq_oe <= 1'b1;
          sdram_dq_o  <= cl3 ? d_b : ram_rdata;
        end else begin
          sdram_dq_oe <= 1'b0;
          sdram_dq_o  <= '0;
        end
      end
    end
  end

  sdram_emu_ram #(.AW(MEM_AW)) u_ram (
    .clk   (clk),
    .en    (sdram_cke),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (sdram_dq_i),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_sdram_device_emu.sv
// Directed bench for sdram_device_emu: read beats are scheduled into an
// expected queue at command time and matched cycle by cycle on the dq bus.
module tb_sdram_device_emu;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sdram_cke;
  logic        sdram_csn, sdram_rasn, sdram_casn, sdram_wen;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_dqm;
  logic [15:0] sdram_dq_i;
  logic [15:0] sdram_dq_o;
  logic        sdram_dq_oe;
  logic [9:0]  mode_reg;
  logic [3:0]  err;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int n, k;
  logic [47:0] exp_q[$];
  logic [47:0] beat;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  sdram_device_emu dut (
    .clk         (clk),
    .reset       (reset),
    .sdram_cke   (sdram_cke),
    .sdram_csn   (sdram_csn),
    .sdram_rasn  (sdram_rasn),
    .sdram_casn  (sdram_casn),
    .sdram_wen   (sdram_wen),
    .sdram_ba    (sdram_ba),
    .sdram_addr  (sdram_addr),
    .sdram_dqm   (sdram_dqm),
    .sdram_dq_i  (sdram_dq_i),
    .sdram_dq_o  (sdram_dq_o),
    .sdram_dq_oe (sdram_dq_oe),
    .mode_reg    (mode_reg),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, edge_cnt, obs, exp);
    end
  endtask

  // Drive one command; it is sampled at the next posedge, recorded in n.
  task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] d, input logic [1:0] m);
    @(posedge clk);
    #2;
    {sdram_csn, sdram_rasn, sdram_casn, sdram_wen} = c;
    sdram_ba   = ba;
    sdram_addr = a;
    sdram_dq_i = d;
    sdram_dqm  = m;
    n = edge_cnt + 1;
  endtask

  task automatic nop(input int cnt);
    repeat (cnt) drive(CMD_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
  endtask

  task automatic push(input int e, input logic [15:0] d);
    exp_q.push_back({32'(e), d});
  endtask

  // Values on the bus at a negedge are what the controller samples at the next posedge.
  always @(negedge clk) begin
    if (sdram_cke) begin
      if (exp_q.size() > 0 && exp_q[0][47:16] == 32'(edge_cnt + 1)) begin
        beat = exp_q.pop_front();
        check("rd_beat", {15'd0, sdram_dq_oe, sdram_dq_o}, {16'd1, beat[15:0]});
      end else begin
        check("rd_idle", {15'd0, sdram_dq_oe, sdram_dq_o}, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    sdram_cke = 1'b1;
    {sdram_csn, sdram_rasn, sdram_casn, sdram_wen} = CMD_NOP;
    sdram_ba = '0; sdram_addr = '0; sdram_dqm = '0; sdram_dq_i = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_dq_oe", 32'(sdram_dq_oe), 32'd0);
    check("rst_dq_o", 32'(sdram_dq_o), 32'd0);
    check("rst_mode", 32'(mode_reg), 32'h020);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    // CL2/BL2, two-beat write with auto-precharge
    drive(CMD_MRS, 2'd0, 13'h021, 16'd0, 2'b00);
    nop(1);
    check("mrs_021", 32'(mode_reg), 32'h021);
    drive(CMD_ACT, 2'd1, 13'h0005, 16'd0, 2'b00);
    drive(CMD_WRITE, 2'd1, 13'h404, 16'h1111, 2'b00);
    drive(CMD_NOP, 2'd0, 13'd0, 16'h2222, 2'b00);
    nop(2);
    drive(CMD_ACT, 2'd1, 13'h0005, 16'd0, 2'b00);
    nop(1);
    check("ap_closed", 32'(err), 32'd0);

    drive(CMD_READ, 2'd1, 13'h004, 16'd0, 2'b00);
    push(n + 2, 16'h1111);
    push(n + 3, 16'h2222);
    nop(4);

    // CL3/BL4: wrapped write then wrapped read
    drive(CMD_MRS, 2'd0, 13'h032, 16'd0, 2'b00);
    nop(1);
    drive(CMD_WRITE, 2'd1, 13'h006, 16'h3333, 2'b00);
    drive(CMD_NOP, 2'd0, 13'd0, 16'h4444, 2'b00);
    drive(CMD_NOP, 2'd0, 13'd0, 16'h1111, 2'b00);
    drive(CMD_NOP, 2'd0, 13'd0, 16'h2222, 2'b00);
    nop(1);
    drive(CMD_READ, 2'd1, 13'h006, 16'd0, 2'b00);
    push(n + 3, 16'h3333);
    push(n + 4, 16'h4444);
    push(n + 5, 16'h1111);
    push(n + 6, 16'h2222);
    nop(7);

    // Single-beat writes (bit 9), byte mask, read dqm
    drive(CMD_MRS, 2'd0, 13'h221, 16'd0, 2'b00);
    nop(1);
    drive(CMD_WRITE, 2'd1, 13'h004, 16'hABCD, 2'b10);
    drive(CMD_NOP, 2'd0, 13'd0, 16'h5555, 2'b00);
    nop(1);
    drive(CMD_READ, 2'd1, 13'h004, 16'd0, 2'b00);
    push(n + 2, 16'h11CD);
    push(n + 3, 16'h2222);
    nop(4);
    drive(CMD_READ, 2'd1, 13'h004, 16'd0, 2'b00);
    push(n + 2, 16'h11CD);
    drive(CMD_NOP, 2'd0, 13'd0, 16'd0, 2'b11);
    nop(4);

    // WRITE cuts off a draining read; then read-after-write
    drive(CMD_READ, 2'd1, 13'h004, 16'd0, 2'b00);
    push(n + 2, 16'h11CD);
    nop(1);
    drive(CMD_WRITE, 2'd1, 13'h005, 16'h6666, 2'b00);
    drive(CMD_READ, 2'd1, 13'h004, 16'd0, 2'b00);
    push(n + 2, 16'h11CD);
    push(n + 3, 16'h6666);
    nop(4);
    check("err_clean", 32'(err), 32'd0);

    // Protocol error flags
    drive(CMD_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
    drive(CMD_READ, 2'd1, 13'h004, 16'd0, 2'b00);
    push(n + 2, 16'h11CD);
    push(n + 3, 16'h6666);
    nop(1);
    check("err_idle_rd", 32'(err), 32'h1);
    nop(3);
    drive(CMD_ACT, 2'd0, 13'h0000, 16'd0, 2'b00);
    drive(CMD_ACT, 2'd0, 13'h0000, 16'd0, 2'b00);
    nop(1);
    check("err_act_open", 32'(err), 32'h3);
    drive(CMD_REF, 2'd0, 13'h000, 16'd0, 2'b00);
    nop(1);
    check("err_ref_open", 32'(err), 32'h7);
    drive(CMD_MRS, 2'd0, 13'h011, 16'd0, 2'b00);
    nop(1);
    check("err_bad_mrs", 32'(err), 32'hF);
    check("mode_bad", 32'(mode_reg), 32'h011);
    drive(CMD_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
    nop(2);
    check("err_sticky", 32'(err), 32'hF);

    // cke low for 3 cycles in a CL3/BL4 read
    drive(CMD_MRS, 2'd0, 13'h032, 16'd0, 2'b00);
    drive(CMD_ACT, 2'd1, 13'h0005, 16'd0, 2'b00);
    nop(1);
    drive(CMD_READ, 2'd1, 13'h006, 16'd0, 2'b00);
    k = n;
    push(k + 6, 16'h3333);
    push(k + 7, 16'h4444);
    push(k + 8, 16'h11CD);
    push(k + 9, 16'h6666);
    nop(1);
    repeat (3) begin
      @(posedge clk);
      #2;
      sdram_cke = 1'b0;
    end
    @(posedge clk);
    #2;
    sdram_cke = 1'b1;
    nop(10);

    // Asynchronous reset in the middle of a burst
    drive(CMD_READ, 2'd1, 13'h006, 16'd0, 2'b00);
    push(n + 3, 16'h3333);
    push(n + 4, 16'h4444);
    push(n + 5, 16'h11CD);
    push(n + 6, 16'h6666);
    nop(4);
    check("beats_left", 32'(exp_q.size()), 32'd3);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_oe", 32'(sdram_dq_oe), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    check("rst_mid_mode", 32'(mode_reg), 32'h020);
    @(posedge clk);
    #2;
    reset = 1'b0;
    nop(4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_device_emu.md
Name: sdram_device_emu

Overview:
- Synthesizable SDR SDRAM responder: the device end of the x16 SDRAM command bus driven by the team's SDRAM controller.
- Decodes CS/RAS/CAS/WE commands, tracks per-bank open rows, mode register and bursts, and serves data from an on-chip byte-enabled RAM.
- Used to run the SoC on boards without SDRAM and as a cycle-accurate bench partner for controller verification.

Parameters:
- MEM_AW, 14, internal 16-bit word address width (2^MEM_AW words); linear address {ba,row,col} truncated to low MEM_AW bits.
- COL_W, 9, column address bits used from sdram_addr.
- ROW_W, 13, row address bits.

Ports:
- clk  in  1  single clock; sdram_clk of the controller.
- reset  in  1  asynchronous, active-high reset.
- sdram_cke  in  1  clock enable.
- sdram_csn, sdram_rasn, sdram_casn, sdram_wen  in  1 each  command {csn,rasn,casn,wen}.
- sdram_ba  in  2  bank select.
- sdram_addr  in  13  row / column / mode bits; A10 = auto-precharge or all-banks.
- sdram_dqm  in  2  byte mask; bit0 = dq[7:0].
- sdram_dq_i  in  16  write data from bus.
- sdram_dq_o  out  16  read data to bus.
- sdram_dq_oe  out  1  drive enable for the top-level tristate.
- mode_reg  out  10  last loaded mode register.
- err  out  4  sticky protocol error flags.

Behaviour:
- Reset (async, active-high): dq_o=0, dq_oe=0, mode_reg=10'h020 (CL2, BL1, sequential), err=0, all banks idle, burst and CAS pipelines empty.
- Commands are sampled at posedge clk only when cke=1. While cke=0, nothing is decoded, burst/CAS pipelines and outputs hold, and no RAM write occurs.
- Encodings ({csn,rasn,casn,wen}):
  - 1xxx DSEL, 0111 NOP: no action; an active burst continues.
  - 0011 ACT: open_row[ba]=addr, active[ba]=1. If the bank is already active, set err[1] and overwrite.
  - 0101 READ / 0100 WRITE: column=addr[COL_W-1:0], autoprecharge=addr[10]. Access to an idle bank sets err[0] and the access is still performed using the stale row.
  - 0010 PRE: addr[10]=1 closes all banks, else closes bank ba.
  - 0001 REF: any bank active sets err[2]; otherwise no action.
  - 0000 MRS: mode_reg=addr[9:0]. CL (bits 6:4) not 2/3, interleaved (bit 3), or BL (bits 2:0) not 0..3 sets err[3] and behaves as CL2/BL1.
  - 0110 BST: terminates the current burst; beats already in the CAS pipeline still complete.
- Burst:
  - Length BL = 1/2/4/8 from mode_reg[2:0], sequential order.
  - Column increments and wraps inside the BL-aligned block (col[2:0] for BL8).
  - A new READ/WRITE terminates the running burst immediately and starts the new one.
  - Auto-precharge closes the bank after the last beat.
- Write mode_reg[9]=1: writes are single-beat regardless of BL.
- Write timing: beat k is taken from dq_i/dqm at the edge where the WRITE was sampled +k. Byte j is written only if dqm[j]=0.
- Read timing:
  - Command edge N. Beat k is driven on dq_o with dq_oe=1 in the cycle ending at edge N+CL+k, so the controller samples at edge N+CL+k.
  - Implementation: RAM read at edge N+k, then an (CL-1)-deep output register pipeline.
  - DQM on reads has 2-cycle latency: dqm=11 sampled at edge M forces dq_oe=0 and dq_o=0 for the beat sampled at M+2.
- Simultaneous events:
  - A WRITE arriving while read beats are still draining: drain beats are dropped, and dq_oe drops at the same edge the WRITE is sampled.
  - Same-address write then read: the read returns the new data (RAM is write-first).
- Reset mid-burst clears all state at once. RAM contents are not cleared.
- Timing parameters (tRCD, tRP, tRC) are not checked.

Decomposition:
- Package sdram_pkg, shared with the controller: CMD_* 4-bit encodings, mode-register field positions, BL/CL decode constants.
- One sub-module, sdram_emu_ram: 2^MEM_AW x 16 synchronous RAM with 2-bit active-high byte enables, single port, write-first.
- Top level holds the command decoder, bank table, burst counter FSM (IDLE, RBURST, WBURST) and CAS shift pipeline.

Test Plan:
- Reset, MRS addr=0x021 (CL2, BL2), ACT ba=1 row=0x0005, WRITE col=0x004 A10=1 with dq 0x1111 then 0x2222, dqm=00 -> RAM words at col 4 and 5 written; bank 1 idle after burst; err=0.
- ACT ba=1 row=5, READ col=4 at edge N -> dq_oe=1 and dq_o=0x1111 sampled at N+2, 0x2222 at N+3; dq_oe=0 at N+4.
- MRS CL3/BL4 (0x032), READ col=6 -> data from col 6,7,4,5 at N+3..N+6 (wrap within block).
- WRITE 0xABCD with dqm=10 over 0x1111 -> readback 0x11CD. Read with dqm=11 asserted 2 cycles before beat 1 -> beat 1 not driven (dq_oe=0).
- READ to idle bank -> err[0]=1; ACT on open bank -> err[1]=1; REF with bank open -> err[2]=1; MRS CL=1 -> err[3]=1. Flags stay set until reset.
- cke=0 for 3 cycles mid BL4 read -> beats delayed by exactly 3 cycles with values unchanged; async reset asserted mid-burst -> dq_oe=0 immediately, err=0, mode_reg=0x020.
